// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// slave: the arbiter side; master: the requesters/ALU/consumer side.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_ctrl;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_src2;
    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_ctrl;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_src2;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_cout;
    logic              alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_cout;
    logic              rsp_overflow;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_ctrl, req0_src1, req0_src2,
        input  req1_valid, req1_ctrl, req1_src1, req1_src2,
        output req0_ready, req1_ready,
        output alu_src1, alu_src2, alu_control,
        input  alu_result, alu_zero, alu_cout, alu_overflow,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_ctrl, req0_src1, req0_src2,
        output req1_valid, req1_ctrl, req1_src1, req1_src2,
        input  req0_ready, req1_ready,
        input  alu_src1, alu_src2, alu_control,
        output alu_result, alu_zero, alu_cout, alu_overflow,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Optional opcode check enabled by defining ALU_ARB_OPCHK_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; ready goes to the granted requester
// S_EXEC | latched operands drive the ALU; result captured at cycle end
// S_RESP | response held until the consumer takes it
module alu_arbiter #(
    parameter int DATA_W   = 32,
    parameter bit RST_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_id;
    logic [3:0]        r_alu_control;
    logic [DATA_W-1:0] r_alu_src1;
    logic [DATA_W-1:0] r_alu_src2;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_cout;
    logic              r_rsp_overflow;

    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic [3:0]        w_op_ctrl;
    logic [DATA_W-1:0] w_op_src1;
    logic [DATA_W-1:0] w_op_src2;
    logic              w_legal;
    logic              w_skip;

    // r_last = 1 means requester 1 was granted most recently, so requester 0 wins a tie
    assign w_ready0  = ~rst_n & (r_state == S_IDLE) & bus.req0_valid & (~bus.req1_valid | r_last);
    assign w_ready1  = ~rst_n & (r_state == S_IDLE) & bus.req1_valid & (~bus.req0_valid | ~r_last);
    assign w_accept  = w_ready0 | w_ready1;
    assign w_op_ctrl = w_ready1 ? bus.req1_ctrl : bus.req0_ctrl;
    assign w_op_src1 = w_ready1 ? bus.req1_src1 : bus.req0_src1;
    assign w_op_src2 = w_ready1 ? bus.req1_src2 : bus.req0_src2;

`ifdef ALU_ARB_OPCHK_EN
    logic r_skip;
    logic r_rsp_err;

    always_comb begin
        case (w_op_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_skip    <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept)
                r_skip <= ~w_legal;
            if (r_state == S_EXEC)
                r_rsp_err <= r_skip;
        end
    end

    assign w_skip      = r_skip;
    assign bus.rsp_err = r_rsp_err;
`else
    assign w_legal     = 1'b1;
    assign w_skip      = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state        <= S_IDLE;
            r_last         <= ~RST_PRIO;
            r_id           <= 1'b0;
            r_alu_control  <= '0;
            r_alu_src1     <= '0;
            r_alu_src2     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_cout     <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id   <= w_ready1;
                        r_last <= w_ready1;
                        // a rejected opcode never reaches the ALU pins
                        if (w_legal) begin
                            r_alu_control <= w_op_ctrl;
                            r_alu_src1    <= w_op_src1;
                            r_alu_src2    <= w_op_src2;
                        end
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_valid    <= 1'b1;
                    r_rsp_id       <= r_id;
                    r_rsp_result   <= w_skip ? '0 : bus.alu_result;
                    r_rsp_zero     <= ~w_skip & bus.alu_zero;
                    r_rsp_cout     <= ~w_skip & bus.alu_cout;
                    r_rsp_overflow <= ~w_skip & bus.alu_overflow;
                    r_alu_control  <= '0;
                    r_alu_src1     <= '0;
                    r_alu_src2     <= '0;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready   = w_ready0;
    assign bus.req1_ready   = w_ready1;
    assign bus.alu_control  = r_alu_control;
    assign bus.alu_src1     = r_alu_src1;
    assign bus.alu_src2     = r_alu_src2;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_zero     = r_rsp_zero;
    assign bus.rsp_cout     = r_rsp_cout;
    assign bus.rsp_overflow = r_rsp_overflow;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (round-robin grant, fixed latency, one in flight).
module tb_alu_arbiter;
    localparam bit RST_PRIO = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32)) bus ();

    alu_arbiter #(.DATA_W(32), .RST_PRIO(RST_PRIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // shared ALU: returns {overflow, cout, zero, result}
    function automatic logic [34:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0111: r = {31'd0, $signed(a) < $signed(b)};
            4'b1100: r = ~(a | b);
            4'b1101: r = a ^ b;
            default: r = (a + 32'h1234_5678) ^ b;
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    logic [34:0] w_alu;
    assign w_alu            = alu_ref(bus.alu_control, bus.alu_src1, bus.alu_src2);
    assign bus.alu_result   = w_alu[31:0];
    assign bus.alu_zero     = w_alu[32];
    assign bus.alu_cout     = w_alu[33];
    assign bus.alu_overflow = w_alu[34];

    function automatic bit op_legal(input logic [3:0] c);
`ifdef ALU_ARB_OPCHK_EN
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
`else
        return 1'b1;
`endif
    endfunction

    // expected response {err, overflow, cout, zero, result}
    function automatic logic [35:0] exp_rsp(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (!op_legal(c))
            return {1'b1, 35'd0};
        return {1'b0, alu_ref(c, a, b)};
    endfunction

    function automatic logic [35:0] obs();
        return {bus.rsp_err, bus.rsp_overflow, bus.rsp_cout, bus.rsp_zero, bus.rsp_result};
    endfunction

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_ctrl = '0; bus.req0_src1 = '0; bus.req0_src2 = '0;
        bus.req1_valid = 1'b0; bus.req1_ctrl = '0; bus.req1_src1 = '0; bus.req1_src2 = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
    endtask

    // drives one requester alone until accepted, then waits for its response (rsp_ready held 1)
    task automatic do_op(input bit id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output bit ok, output int lat, output logic [35:0] rsp, output bit rid,
                         output logic [3:0] exec_ctrl);
        bit acc;
        acc = 1'b0; ok = 1'b0; lat = 0; rsp = '0; rid = 1'b0; exec_ctrl = '0;
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_src1 = a; bus.req1_src2 = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_src1 = a; bus.req0_src2 = b;
        end
        for (int n = 0; n < 8 && !acc; n++) begin
            #1;
            acc = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (acc) begin
            for (int n = 1; n <= 8 && !ok; n++) begin
                #1;
                if (n == 1) exec_ctrl = bus.alu_control;
                if (bus.rsp_valid) begin
                    ok = 1'b1; lat = n; rsp = obs(); rid = bus.rsp_id;
                end
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
        end
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp_flags: got %b expected 0000", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_zero});
        end
        checks++; if (bus.rsp_result !== 32'd0) begin
            errors++; $display("FAIL reset_rsp_result: got %h expected 0", bus.rsp_result);
        end
        checks++; if ({bus.alu_control, bus.alu_src1, bus.alu_src2} !== 68'd0) begin
            errors++; $display("FAIL reset_alu: got %h expected 0", {bus.alu_control, bus.alu_src1, bus.alu_src2});
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_single();
        bit ok; int lat; logic [35:0] rsp; bit rid; logic [3:0] ec;
        do_op(1'b0, 4'b0010, 32'd5, 32'd7, ok, lat, rsp, rid, ec);
        checks++; if (ok !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL single_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat);
        end
        checks++; if (rid !== 1'b0) begin
            errors++; $display("FAIL single_id: got %0d expected 0", rid);
        end
        checks++; if (rsp !== {4'b0000, 32'd12}) begin
            errors++; $display("FAIL single_rsp: got %h expected %h", rsp, {4'b0000, 32'd12});
        end
        checks++; if (ec !== 4'b0010) begin
            errors++; $display("FAIL single_exec_ctrl: got %b expected 0010", ec);
        end
    endtask

    task automatic test_overflow();
        bit ok; int lat; logic [35:0] rsp; bit rid; logic [3:0] ec;
        do_op(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'd1, ok, lat, rsp, rid, ec);
        checks++; if (ok !== 1'b1 || rid !== 1'b1) begin
            errors++; $display("FAIL ovf_id: got ok=%0d id=%0d expected ok=1 id=1", ok, rid);
        end
        checks++; if (rsp[31:0] !== 32'h8000_0000 || rsp[34] !== 1'b1 || rsp[33] !== 1'b0) begin
            errors++; $display("FAIL ovf_rsp: got result=%h ov=%b cout=%b expected 80000000 1 0", rsp[31:0], rsp[34], rsp[33]);
        end
    endtask

    task automatic test_simultaneous();
        int          got;
        int          acc_cyc[$];
        bit          rid_q[4];
        logic [35:0] rsp_q[4];
        apply_reset();
        got = 0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0110; bus.req0_src1 = 32'd3;     bus.req0_src2 = 32'd3;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b0001; bus.req1_src1 = 32'h0000_00F0; bus.req1_src2 = 32'h0000_000F;
        for (int n = 0; n < 40 && got < 4; n++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) acc_cyc.push_back(n);
            if (bus.rsp_valid) begin
                rid_q[got] = bus.rsp_id;
                rsp_q[got] = obs();
                got++;
            end
            @(posedge clk); @(negedge clk);
        end
        clear_inputs();
        checks++; if (got !== 4) begin
            errors++; $display("FAIL sim_count: got %0d responses expected 4", got);
        end
        for (int i = 0; i < got; i++) begin
            checks++; if (rid_q[i] !== 1'(i % 2)) begin
                errors++; $display("FAIL sim_order[%0d]: got id %0d expected %0d", i, rid_q[i], i % 2);
            end
            checks++; if (rsp_q[i] !== ((i % 2) ? exp_rsp(4'b0001, 32'hF0, 32'h0F) : exp_rsp(4'b0110, 32'd3, 32'd3))) begin
                errors++; $display("FAIL sim_rsp[%0d]: got %h", i, rsp_q[i]);
            end
        end
        checks++; if (got < 2 || rsp_q[0][32:0] !== {1'b1, 32'd0} || rsp_q[1][31:0] !== 32'hFF) begin
            errors++; $display("FAIL sim_values: got r0=%h r1=%h expected zero/0 and FF", rsp_q[0], rsp_q[1]);
        end
        checks++; if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 3) begin
            errors++; $display("FAIL sim_spacing: got %0d accepts, expected spacing 3", acc_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        bit          seen;
        logic [35:0] exp;
        apply_reset();
        exp  = exp_rsp(4'b0111, 32'd2, 32'd9);
        seen = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0111; bus.req0_src1 = 32'd2; bus.req0_src2 = 32'd9;
        bus.req1_valid = 1'b1; bus.req1_ctrl = 4'b1101; bus.req1_src1 = 32'hAA; bus.req1_src2 = 32'h55;
        for (int n = 0; n < 10 && !seen; n++) begin
            #1;
            seen = bus.rsp_valid;
            if (!seen) begin @(posedge clk); @(negedge clk); end
        end
        checks++; if (!seen) begin
            errors++; $display("FAIL bp_timeout: rsp_valid never rose");
        end
        for (int k = 0; k < 5 && seen; k++) begin
            if (k > 0) begin @(posedge clk); @(negedge clk); #1; end
            checks++; if ({bus.rsp_valid, bus.rsp_id, obs()} !== {1'b1, 1'b0, exp}) begin
                errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", k, {bus.rsp_valid, bus.rsp_id, obs()}, {1'b1, 1'b0, exp});
            end
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, {bus.req0_ready, bus.req1_ready});
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        checks++; if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_release: got %b expected 001", {bus.rsp_valid, bus.req0_ready, bus.req1_ready});
        end
        clear_inputs();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit ok; int lat; logic [35:0] rsp; bit rid; logic [3:0] ec;
        bus.req0_valid = 1'b1; bus.req0_ctrl = 4'b0010; bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd20;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        #1;
        checks++; if ({bus.alu_control, bus.alu_src1} !== {4'b0010, 32'd10}) begin
            errors++; $display("FAIL mid_exec_drive: got %h expected 2/0000000a", {bus.alu_control, bus.alu_src1});
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        checks++; if ({bus.rsp_valid, bus.req0_ready, bus.rsp_err, obs(), bus.alu_control, bus.alu_src1} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got rv=%b rdy=%b rsp=%h alu=%h", bus.rsp_valid, bus.req0_ready, obs(), bus.alu_control);
        end
        @(posedge clk); @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_rsp: got %b expected 0", bus.rsp_valid);
        end
        @(negedge clk);
        do_op(1'b0, 4'b0110, 32'd100, 32'd1, ok, lat, rsp, rid, ec);
        checks++; if (ok !== 1'b1 || lat !== 2 || rid !== 1'b0 || rsp[31:0] !== 32'd99) begin
            errors++; $display("FAIL mid_recover: got ok=%0d lat=%0d id=%0d result=%h expected 1 2 0 63", ok, lat, rid, rsp[31:0]);
        end
    endtask

    task automatic test_opchk();
        bit ok; int lat; logic [35:0] rsp; bit rid; logic [3:0] ec;
        logic [35:0] exp;
        logic [3:0]  exp_ctrl;
`ifdef ALU_ARB_OPCHK_EN
        exp      = {1'b1, 35'd0};
        exp_ctrl = 4'b0000;
`else
        exp      = {1'b0, alu_ref(4'b1111, 32'hA, 32'h5)};
        exp_ctrl = 4'b1111;
`endif
        do_op(1'b1, 4'b1111, 32'hA, 32'h5, ok, lat, rsp, rid, ec);
        checks++; if (ok !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL opchk_latency: got ok=%0d lat=%0d expected 1 2", ok, lat);
        end
        checks++; if (rsp !== exp) begin
            errors++; $display("FAIL opchk_rsp: got %h expected %h", rsp, exp);
        end
        checks++; if (ec !== exp_ctrl) begin
            errors++; $display("FAIL opchk_alu_ctrl: got %b expected %b", ec, exp_ctrl);
        end
    endtask

    task automatic test_random();
        bit          busy;
        int          since;
        bit          last;
        bit          g0;
        bit          g1;
        bit          p_id;
        logic [35:0] p_rsp;
        logic [3:0]  p_ctrl;
        logic [31:0] p_src1;
        int          n_rsp;
        apply_reset();
        busy = 1'b0; since = 0; last = ~RST_PRIO; n_rsp = 0;
        p_id = 1'b0; p_rsp = '0; p_ctrl = '0; p_src1 = '0;
        for (int n = 0; n < 400; n++) begin
            bus.req0_valid = ($urandom_range(0, 99) < 55);
            bus.req0_ctrl  = 4'($urandom_range(0, 15));
            bus.req0_src1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            bus.req0_src2  = $urandom();
            bus.req1_valid = ($urandom_range(0, 99) < 55);
            bus.req1_ctrl  = 4'($urandom_range(0, 15));
            bus.req1_src1  = $urandom();
            bus.req1_src2  = ($urandom_range(0, 3) == 0) ? bus.req1_src1 : $urandom();
            bus.rsp_ready  = ($urandom_range(0, 99) < 60);
            #1;
            g0 = !busy && bus.req0_valid && (!bus.req1_valid || last);
            g1 = !busy && bus.req1_valid && (!bus.req0_valid || !last);
            checks++; if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
                errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, {bus.req0_ready, bus.req1_ready}, {g0, g1});
            end
            checks++; if (bus.rsp_valid !== (busy && since >= 2)) begin
                errors++; $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", n, bus.rsp_valid, busy && since >= 2);
            end
            if (busy && since >= 2) begin
                checks++; if ({bus.rsp_id, obs()} !== {p_id, p_rsp}) begin
                    errors++; $display("FAIL rnd_rsp@%0d: got %h expected %h", n, {bus.rsp_id, obs()}, {p_id, p_rsp});
                end
            end
            checks++; if ({bus.alu_control, bus.alu_src1} !== ((busy && since == 1) ? {p_ctrl, p_src1} : 36'd0)) begin
                errors++; $display("FAIL rnd_alu@%0d: got %h", n, {bus.alu_control, bus.alu_src1});
            end
            @(posedge clk);
            if (busy) begin
                if (since >= 2 && bus.rsp_ready) begin
                    busy = 1'b0;
                    n_rsp++;
                end else begin
                    since++;
                end
            end else if (g0 || g1) begin
                busy  = 1'b1;
                since = 1;
                last  = g1;
                p_id  = g1;
                if (g1) begin
                    p_rsp  = exp_rsp(bus.req1_ctrl, bus.req1_src1, bus.req1_src2);
                    p_ctrl = op_legal(bus.req1_ctrl) ? bus.req1_ctrl : 4'b0000;
                    p_src1 = op_legal(bus.req1_ctrl) ? bus.req1_src1 : 32'd0;
                end else begin
                    p_rsp  = exp_rsp(bus.req0_ctrl, bus.req0_src1, bus.req0_src2);
                    p_ctrl = op_legal(bus.req0_ctrl) ? bus.req0_ctrl : 4'b0000;
                    p_src1 = op_legal(bus.req0_ctrl) ? bus.req0_src1 : 32'd0;
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        checks++; if (n_rsp < 20) begin
            errors++; $display("FAIL rnd_progress: got %0d responses expected at least 20", n_rsp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_op();
        test_opchk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: RST_PRIO, 0, requester that wins the first simultaneous contention after reset (0 or 1).
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous reset, active-high: asserting it (value 1) resets the block on the next rising clk edge.
REQ-005 Port: req0_valid/req1_valid  input  1  requester n presents an operation.
REQ-006 Port: req0_ready/req1_ready  output  1  block accepts an operation from requester n this cycle.
REQ-007 Port: req0_ctrl/req1_ctrl  input  4  ALU control code.
REQ-008 Port: req0_src1/req0_src2/req1_src1/req1_src2  input  32  operands.
REQ-009 Port: alu_src1, alu_src2  output  32  operands driven to the shared ALU.
REQ-010 Port: alu_control  output  4  control code driven to the shared ALU.
REQ-011 Port: alu_result  input  32; alu_zero, alu_cout, alu_overflow  input  1 each; combinational ALU outputs.
REQ-012 Port: rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts it.
REQ-013 Port: rsp_id  output  1  requester index; rsp_result  output  32; rsp_zero, rsp_cout, rsp_overflow, rsp_err  output  1 each.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: reqN_ready = 1 only for the granted requester this cycle, 0 for the other; both 0 in EXEC and RESP.
REQ-016 Grant: only one valid -> that one; both valid -> requester not granted last (round-robin); none valid -> no grant, stay IDLE.
REQ-017 On reqN_valid & reqN_ready: latch ctrl, src1, src2, id=N; update last-grant to N; go to EXEC.
REQ-018 EXEC (one cycle): alu_src1/alu_src2/alu_control driven from latched registers; at end of cycle capture alu_result/zero/cout/overflow into rsp registers; go to RESP.
REQ-019 RESP: rsp_valid = 1 with stable rsp_* until rsp_ready = 1; on rsp_valid & rsp_ready go to IDLE next cycle.
REQ-020 Latency: accept at edge N -> rsp_valid high in cycle N+2; minimum spacing between accepts 3 cycles.
REQ-021 Outside EXEC, alu_src1 = alu_src2 = 0 and alu_control = 4'b0000.
REQ-022 Requests changing while not ready are ignored; no request is lost or duplicated; a requester withdrawing valid before acceptance is legal.
REQ-023 rsp_err = 0 for every accepted operation unless REQ-027 applies.

Reset
REQ-024 While rst_n = 1 at a rising edge: state <= IDLE, rsp_valid <= 0, rsp_id/rsp_result/rsp_zero/rsp_cout/rsp_overflow/rsp_err <= 0, last-grant <= ~RST_PRIO, latched ops <= 0.
REQ-025 Reset during EXEC or RESP discards the in-flight operation; no response is emitted for it.
REQ-026 reqN_ready = 0 in any cycle where rst_n = 1.

Configuration
REQ-027 Macro ALU_ARB_OPCHK_EN defined: an accepted ctrl not in {0000,0001,0010,0110,0111,1100,1101} skips the ALU (alu_* stay idle values), responds in RESP with rsp_err = 1, rsp_result = 0, flags = 0, same latency.
REQ-028 Macro undefined: no code check; every ctrl is forwarded to the ALU; rsp_err is tied 0.

Verification
REQ-029 Single req0: ctrl=0010, src1=5, src2=7 -> rsp_valid in cycle N+2, rsp_id=0, rsp_result=12, zero=0.
REQ-030 Simultaneous: req0 (0110, 3, 3) and req1 (0001, F0, 0F) both held valid after reset -> req0 first (result 0, zero=1), then req1 (result FF); then alternating order.
REQ-031 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, both readys 0, no new accept; rsp_ready=1 -> IDLE next cycle.
REQ-032 Overflow passthrough: ctrl=0010, src1=7FFFFFFF, src2=1 -> rsp_result=80000000, rsp_overflow=1, rsp_cout=0.
REQ-033 Reset mid-op: assert rst_n during EXEC -> no rsp_valid, all outputs 0 next cycle, next request accepted normally.
REQ-034 With ALU_ARB_OPCHK_EN: ctrl=1111 -> rsp_err=1, rsp_result=0, alu_control stays 0000; without macro -> rsp_err=0.
